uart_transmitter: RTL and testbench

Serial transmit half of the UART. Accepts parallel words from the host bus into an internal FIFO and shifts each word out as an asynchronous serial frame: one start bit, DATA_SIZE data bits LSB first, one stop bit. Exposes an 8-bit status word for the bus-side register map. Sits between the bus interface and the TX pin.

---
 rtl/uart_transmitter.sv | 150 +++++++++++++++
 tb/tb_uart_transmitter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered serial transmitter.
// Host words are queued in a circular FIFO and shifted out as
// start bit, DATA_SIZE data bits (LSB first), stop bit.
// Back-to-back frames are sent without an idle gap.
module uart_transmitter #(
  parameter int DATA_SIZE      = 8,
  parameter int SIZE_FIFO      = 8,
  parameter int CLKS_PER_BIT   = 1,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 write_data,
  input  logic [DATA_SIZE-1:0] bus_data,
  output logic                 serial_data_out,
  output logic [7:0]           status_register
);

  localparam int PW   = $clog2(SIZE_FIFO);
  localparam int CNTW = $clog2(SIZE_FIFO + 1);
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_SIZE-1:0]      mem_q [SIZE_FIFO];
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]           count_q;
  logic                      overflow_q;

  state_t                    state_q;
  logic [CW-1:0]             clk_cnt_q;
  logic [BIT_COUNT_SIZE-1:0] bit_cnt_q;
  logic [DATA_SIZE-1:0]      shift_q;
  logic                      line_q;
  logic                      tx_done_q;

  logic                      fifo_empty, fifo_full;
  logic                      push, pop, clk_last;
  logic [DATA_SIZE-1:0]      head, shift_nxt;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNTW'(SIZE_FIFO));
  assign head       = mem_q[rd_ptr_q];
  assign shift_nxt  = shift_q >> 1;
  assign clk_last   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  // A push while full is dropped even if the FSM pops in the same cycle.
  assign push = write_data && !fifo_full;
  assign pop  = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && clk_last));

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_data;
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (write_data && fifo_full) overflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame FSM; the TX line is registered alongside each state change.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      line_q    <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          line_q    <= 1'b1;
          clk_cnt_q <= '0;
          if (!fifo_empty) begin
            shift_q <= head;
            line_q  <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (clk_last) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            line_q    <= shift_q[0];
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_last) begin
            clk_cnt_q <= '0;
            shift_q   <= shift_nxt;
            bit_cnt_q <= bit_cnt_q + BIT_COUNT_SIZE'(1);
            if (bit_cnt_q == BIT_COUNT_SIZE'(DATA_SIZE - 1)) begin
              line_q  <= 1'b1;
              state_q <= STOP;
            end else begin
              line_q  <= shift_nxt[0];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (clk_last) begin
            clk_cnt_q <= '0;
            tx_done_q <= 1'b1;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              shift_q <= head;
              line_q  <= 1'b0;
              state_q <= START;
            end else begin
              line_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: begin
          line_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign serial_data_out = line_q;
  assign status_register = {3'b000, tx_done_q, overflow_q, fifo_full, fifo_empty,
                            (state_q != IDLE)};

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (CLKS_PER_BIT 1, 3, 4) share
// one stimulus stream and are checked every cycle against a frame-position
// reference model, plus directed vector table and hand-written sequences.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int NI = 3;
  localparam int D  = 8;
  localparam int SF = 8;

  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] d;
    logic       eline;
    logic [7:0] est;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst, wr;
  logic [7:0]          din;
  logic [NI-1:0]       line_o;
  logic [NI-1:0][7:0]  st_o;

  always #5 clk = ~clk;

  uart_transmitter #(.DATA_SIZE(8), .SIZE_FIFO(8), .CLKS_PER_BIT(1)) d1 (
    .clk(clk), .reset_n(rst), .write_data(wr), .bus_data(din),
    .serial_data_out(line_o[0]), .status_register(st_o[0]));
  uart_transmitter #(.DATA_SIZE(8), .SIZE_FIFO(8), .CLKS_PER_BIT(3)) d3 (
    .clk(clk), .reset_n(rst), .write_data(wr), .bus_data(din),
    .serial_data_out(line_o[1]), .status_register(st_o[1]));
  uart_transmitter #(.DATA_SIZE(8), .SIZE_FIFO(8), .CLKS_PER_BIT(4)) d4 (
    .clk(clk), .reset_n(rst), .write_data(wr), .bus_data(din),
    .serial_data_out(line_o[2]), .status_register(st_o[2]));

  // Reference model: a word list per instance plus the number of frame cycles left.
  logic [7:0] mf [NI][SF];
  int         mcnt [NI];
  int         rem [NI];
  logic [7:0] cur [NI];
  logic       movf [NI];
  logic       mdone [NI];

  int   total = 0;
  int   bad = 0;
  logic rec_on = 1'b0;
  int   rec_idx = 0;
  logic rec_q [$];

  function automatic int cpb_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic model_step(input int i);
    logic full_pre;
    if (rst) begin
      mcnt[i] = 0; rem[i] = 0; movf[i] = 1'b0; mdone[i] = 1'b0;
      return;
    end
    full_pre = (mcnt[i] == SF);
    mdone[i] = (rem[i] == 1);
    if (rem[i] > 0) rem[i] = rem[i] - 1;
    if (rem[i] == 0 && mcnt[i] > 0) begin
      cur[i] = mf[i][0];
      for (int k = 0; k < SF - 1; k++) mf[i][k] = mf[i][k+1];
      mcnt[i] = mcnt[i] - 1;
      rem[i] = (D + 2) * cpb_of(i);
    end
    if (wr) begin
      if (!full_pre) begin
        mf[i][mcnt[i]] = din;
        mcnt[i] = mcnt[i] + 1;
      end else begin
        movf[i] = 1'b1;
      end
    end
  endtask

  function automatic logic exp_line(input int i);
    int pos, b;
    if (rem[i] == 0) return 1'b1;
    pos = (D + 2) * cpb_of(i) - rem[i];
    b = pos / cpb_of(i);
    if (b == 0) return 1'b0;
    if (b <= D) return cur[i][b-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_status(input int i);
    return {3'b000, mdone[i], movf[i], (mcnt[i] == SF), (mcnt[i] == 0), (rem[i] > 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d);
    rst = r; wr = w; din = d;
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    if (rec_on) rec_q.push_back(line_o[rec_idx]);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("model_line[%0d]", i), 32'(line_o[i]), 32'(exp_line(i)));
      check($sformatf("model_status[%0d]", i), 32'(st_o[i]), 32'(exp_status(i)));
    end
  endtask

  vec_t        tbl [15];
  logic [19:0] got20;
  logic [29:0] got30;
  logic [7:0]  words [10];
  logic [7:0]  dec;
  int          busy, thr, base;

  initial begin
    rst = 1'b1; wr = 1'b0; din = 8'h00;

    // Single 0x24 frame on the CLKS_PER_BIT=1 instance, edge by edge.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02};
    tbl[2]  = '{1'b0, 1'b1, 8'h24, 1'b1, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h12};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02};
    for (int k = 0; k < 15; k++) begin
      step(tbl[k].r, tbl[k].w, tbl[k].d);
      check($sformatf("tbl_line[%0d]", k), 32'(line_o[0]), 32'(tbl[k].eline));
      check($sformatf("tbl_status[%0d]", k), 32'(st_o[0]), 32'(tbl[k].est));
    end

    // Back-to-back frames 0x24 then 0x81 with no idle bit between them.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h24);
    step(1'b0, 1'b1, 8'h81);
    got20 = '0;
    got20 = {got20[18:0], line_o[0]};
    check("b2b_not_empty", 32'(st_o[0][1]), 32'd0);
    for (int k = 1; k < 20; k++) begin
      step(1'b0, 1'b0, 8'h00);
      got20 = {got20[18:0], line_o[0]};
      if (k == 10) check("b2b_empty_after_pop", 32'(st_o[0][1]), 32'd1);
    end
    check("b2b_bits", 32'(got20), 32'(20'b0001001001_0100000011));
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 8'h00);

    // Ten consecutive writes into the CLKS_PER_BIT=4 instance: fill, overflow, drain.
    step(1'b1, 1'b0, 8'h00);
    rec_idx = 2; rec_q.delete(); rec_on = 1'b1;
    for (int j = 0; j < 10; j++) begin
      words[j] = 8'($urandom);
      step(1'b0, 1'b1, words[j]);
      if (j == 7) check("ovf_not_full_yet", 32'(st_o[2][2]), 32'd0);
      if (j == 8) begin
        check("ovf_full_after_9", 32'(st_o[2][2]), 32'd1);
        check("ovf_clear_before_drop", 32'(st_o[2][3]), 32'd0);
      end
      if (j == 9) check("ovf_set_on_drop", 32'(st_o[2][3]), 32'd1);
    end
    for (int k = 0; k < 380; k++) step(1'b0, 1'b0, 8'h00);
    rec_on = 1'b0;
    for (int j = 0; j < 9; j++) begin
      base = 1 + 40 * j;
      check($sformatf("ovf_start_bit[%0d]", j), 32'(rec_q[base]), 32'd0);
      for (int b = 0; b < 8; b++) dec[b] = rec_q[base + 4 * (b + 1) + 2];
      check($sformatf("ovf_word[%0d]", j), 32'(dec), 32'(words[j]));
    end
    check("ovf_no_tenth_frame", 32'(rec_q[361]), 32'd1);
    check("ovf_sticky", 32'(st_o[2][3]), 32'd1);

    // Reset in the middle of a data bit drops the frame and the queued word.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h3C);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("rst_line", 32'(line_o[0]), 32'd1);
    check("rst_status", 32'(st_o[0]), 32'h02);
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("rst_quiet_line[%0d]", i), 32'(line_o[i]), 32'd1);
        check($sformatf("rst_quiet_status[%0d]", i), 32'(st_o[i]), 32'h02);
      end
    end

    // Baud timing on the CLKS_PER_BIT=3 instance with word 0x01.
    step(1'b1, 1'b0, 8'h00);
    rec_idx = 1; rec_q.delete(); rec_on = 1'b1;
    busy = 0;
    step(1'b0, 1'b1, 8'h01);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (st_o[1][0]) busy++;
    end
    rec_on = 1'b0;
    got30 = '0;
    for (int k = 1; k <= 30; k++) got30 = {got30[28:0], rec_q[k]};
    check("baud_bits", 32'(got30), 32'(30'b000_111_000_000_000_000_000_000_000_111));
    check("baud_busy_cycles", 32'(busy), 32'd30);

    // Random traffic alternating heavy bursts and sparse writes, rare resets.
    step(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 1500; c++) begin
      thr = ((c / 150) % 2 == 1) ? 60 : 8;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < thr), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
